// File: rtl/gpu_raster_engine.sv
// gpu_raster_engine: APB-programmed pixel/rectangle/clear rasterizer fed by a command FIFO
module gpu_raster_engine #(
  parameter int XW    = 11,
  parameter int YW    = 10,
  parameter int CW    = 8,
  parameter int DEPTH = 4,
  parameter int XMAX  = 639,
  parameter int YMAX  = 479
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic [31:0]   pAddr_i,
  input  logic [31:0]   pDataWrite_i,
  input  logic          pSel_i,
  input  logic          pEnable_i,
  input  logic          pWrite_i,
  output logic [31:0]   pDataRead_o,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic [CW-1:0] r_o,
  output logic [CW-1:0] g_o,
  output logic [CW-1:0] b_o,
  output logic          pix_valid_o,
  input  logic          pix_ready_i
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2;
  localparam logic [1:0] OP_NOP = 2'd0, OP_PIXEL = 2'd1, OP_RECT = 2'd2;
  localparam logic [XW-1:0] XM = XW'(XMAX);
  localparam logic [YW-1:0] YM = YW'(YMAX);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [1:0]      op;
    logic [XW-1:0]   ax;
    logic [YW-1:0]   ay;
    logic [XW-1:0]   bx;
    logic [YW-1:0]   by;
    logic [3*CW-1:0] col;
  } cmd_t;

  cmd_t            mem_q [DEPTH];
  cmd_t            cur_q, cur_d;
  logic [3*CW-1:0] col_q, col_d;
  logic [XW-1:0]   pax_q, pax_d, pbx_q, pbx_d;
  logic [YW-1:0]   pay_q, pay_d, pby_q, pby_d;
  logic [AW-1:0]   wp_q, rp_q;
  logic [AW:0]     cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic [1:0]      state_q, state_d;
  logic [XW-1:0]   x_q, x_d, xlo_q, xlo_d, xhi_q, xhi_d;
  logic [YW-1:0]   y_q, y_d, yhi_q, yhi_d;
  logic            valid_q, valid_d;
  logic [2:0]      a;
  logic            wr, cmd_wr, push, pop, full, empty;
  logic [31:0]     status;
  logic [XW-1:0]   ax, bx, xl, xh;
  logic [YW-1:0]   ay, by, yl, yh;
  logic            unused_ok;

  assign unused_ok = ^{pAddr_i, pDataWrite_i};
  assign a      = pAddr_i[4:2];
  assign wr     = pSel_i & pEnable_i & pWrite_i;
  assign cmd_wr = wr & (a == 3'd3);
  assign full   = cnt_q == FULL_CNT;
  assign empty  = cnt_q == '0;
  // fullness is judged before any same-cycle pop
  assign push   = cmd_wr & ~full;
  assign pop    = (state_q == IDLE) & ~empty;
  assign cnt_d  = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  assign ovf_d  = (wr & (a == 3'd4)) ? 1'b0 : ovf_q | (cmd_wr & full);

  assign col_d = (wr & (a == 3'd0)) ? pDataWrite_i[3*CW-1:0] : col_q;
  assign pax_d = (wr & (a == 3'd1)) ? pDataWrite_i[XW-1:0] : pax_q;
  assign pay_d = (wr & (a == 3'd1)) ? pDataWrite_i[16+YW-1:16] : pay_q;
  assign pbx_d = (wr & (a == 3'd2)) ? pDataWrite_i[XW-1:0] : pbx_q;
  assign pby_d = (wr & (a == 3'd2)) ? pDataWrite_i[16+YW-1:16] : pby_q;

  assign status = {16'd0, 8'(cnt_q), 4'd0, ovf_q, state_q != IDLE, full, empty};
  assign pDataRead_o = (a == 3'd0) ? 32'(col_q)
                     : (a == 3'd1) ? (32'(pay_q) << 16) | 32'(pax_q)
                     : (a == 3'd2) ? (32'(pby_q) << 16) | 32'(pbx_q)
                     : (a == 3'd3) ? status
                     : 32'd0;

  assign ax = (cur_q.ax > XM) ? XM : cur_q.ax;
  assign bx = (cur_q.bx > XM) ? XM : cur_q.bx;
  assign ay = (cur_q.ay > YM) ? YM : cur_q.ay;
  assign by = (cur_q.by > YM) ? YM : cur_q.by;
  // CLEAR (op 3) falls through to the full-screen bounds
  assign xl = (cur_q.op == OP_RECT) ? ((ax < bx) ? ax : bx) : (cur_q.op == OP_PIXEL) ? ax : '0;
  assign xh = (cur_q.op == OP_RECT) ? ((ax < bx) ? bx : ax) : (cur_q.op == OP_PIXEL) ? ax : XM;
  assign yl = (cur_q.op == OP_RECT) ? ((ay < by) ? ay : by) : (cur_q.op == OP_PIXEL) ? ay : '0;
  assign yh = (cur_q.op == OP_RECT) ? ((ay < by) ? by : ay) : (cur_q.op == OP_PIXEL) ? ay : YM;

  always_comb begin
    state_d = state_q;
    cur_d   = pop ? mem_q[rp_q] : cur_q;
    x_d     = x_q;
    y_d     = y_q;
    xlo_d   = xlo_q;
    xhi_d   = xhi_q;
    yhi_d   = yhi_q;
    valid_d = valid_q;
    if (state_q == IDLE) begin
      state_d = pop ? LOAD : IDLE;
    end else if (state_q == LOAD) begin
      if (cur_q.op == OP_NOP) begin
        state_d = IDLE;
      end else begin
        x_d     = xl;
        y_d     = yl;
        xlo_d   = xl;
        xhi_d   = xh;
        yhi_d   = yh;
        valid_d = 1'b1;
        state_d = RUN;
      end
    end else if (valid_q & pix_ready_i) begin
      if (x_q == xhi_q) begin
        x_d = xlo_q;
        if (y_q == yhi_q) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else begin
          y_d = y_q + 1'b1;
        end
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cur_q   <= '0;
      col_q   <= '0;
      pax_q   <= '0;
      pay_q   <= '0;
      pbx_q   <= '0;
      pby_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      xlo_q   <= '0;
      xhi_q   <= '0;
      yhi_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      cur_q   <= cur_d;
      col_q   <= col_d;
      pax_q   <= pax_d;
      pay_q   <= pay_d;
      pbx_q   <= pbx_d;
      pby_q   <= pby_d;
      wp_q    <= wp_q + AW'(push);
      rp_q    <= rp_q + AW'(pop);
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      xlo_q   <= xlo_d;
      xhi_q   <= xhi_d;
      yhi_q   <= yhi_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= {pDataWrite_i[1:0], pax_q, pay_q, pbx_q, pby_q, col_q};
  end

  assign x_o               = x_q;
  assign y_o               = y_q;
  assign {r_o, g_o, b_o}   = cur_q.col;
  assign pix_valid_o       = valid_q;
endmodule

// File: doc/gpu_raster_engine.md
GPU_RASTER_ENGINE -- requirements
Module: gpu_raster_engine

Interface
REQ-001 SHALL have parameter XW, default 11, pixel X coordinate width.
REQ-002 SHALL have parameter YW, default 10, pixel Y coordinate width.
REQ-003 SHALL have parameter CW, default 8, width of each colour channel.
REQ-004 SHALL have parameter DEPTH, default 4, command FIFO entries (power of 2, 2..16).
REQ-005 SHALL have parameter XMAX, default 639, largest legal X.
REQ-006 SHALL have parameter YMAX, default 479, largest legal Y.
REQ-007 clk  input  1  single clock; all state updates on rising edge.
REQ-008 n_rst  input  1  reset, synchronous, active-low.
REQ-009 pAddr_i  input  32  APB address; only [4:2] decoded.
REQ-010 pDataWrite_i  input  32  APB write data.
REQ-011 pSel_i  input  1  APB select.
REQ-012 pEnable_i  input  1  APB access phase.
REQ-013 pWrite_i  input  1  APB direction, 1 = write.
REQ-014 pDataRead_o  output  32  APB read data, combinational from pAddr_i.
REQ-015 x_o  output  XW  pixel X.
REQ-016 y_o  output  YW  pixel Y.
REQ-017 r_o / g_o / b_o  output  CW each  pixel colour.
REQ-018 pix_valid_o  output  1  pixel beat valid.
REQ-019 pix_ready_i  input  1  downstream accepts beat.

Function
REQ-020 Write strobe SHALL be pSel_i & pEnable_i & pWrite_i; no wait states.
REQ-021 Register map SHALL be: 0x00 COLOR {r,g,b} packed LSB-first (b at [CW-1:0]); 0x04 PA {y at [16+YW-1:16], x at [XW-1:0]}; 0x08 PB same layout; 0x0C write = CMD, read = STATUS; 0x10 write = clear overflow.
REQ-022 COLOR/PA/PB SHALL be staging registers, readable at their addresses; other read addresses return 0.
REQ-023 CMD write SHALL push {opcode = pDataWrite_i[1:0], PA, PB, COLOR} into the FIFO if not full at that cycle, else drop and set sticky overflow.
REQ-024 Push-when-full SHALL be rejected even if a pop occurs in the same cycle.
REQ-025 STATUS SHALL be [0] empty, [1] full, [2] busy (state != IDLE), [3] overflow, [15:8] FIFO count, rest 0.
REQ-026 Opcodes SHALL be 0 NOP, 1 PIXEL (one pixel at PA), 2 RECT (filled, PA..PB inclusive), 3 CLEAR (0..XMAX, 0..YMAX).
REQ-027 FSM SHALL be IDLE -> LOAD -> RUN -> IDLE; IDLE pops when FIFO not empty; NOP returns LOAD -> IDLE with no beat.
REQ-028 LOAD SHALL clamp each coordinate to XMAX/YMAX, then order as xmin/xmax, ymin/ymax (swap if PA > PB).
REQ-029 RUN SHALL emit pixels raster order: x inner xmin..xmax, y outer ymin..ymax, colour constant from entry.
REQ-030 A beat SHALL advance only when pix_valid_o & pix_ready_i; outputs SHALL hold stable while valid & !ready.
REQ-031 Accepting last pixel (x = xmax, y = ymax) SHALL return to IDLE; pix_valid_o low in that next cycle.
REQ-032 Latency: CMD write in cycle T into empty FIFO with IDLE engine -> pop T+1, LOAD T+2, first pix_valid_o at T+3.

Reset
REQ-033 n_rst low at a rising edge SHALL clear FIFO, staging registers, overflow, FSM to IDLE, all outputs to 0, overriding any in-progress command.

Verification
REQ-034 Reset: hold n_rst low 1 cycle -> all outputs 0, STATUS read = 0x0000_0001.
REQ-035 PIXEL: COLOR=0x00FF8040, PA x=5 y=7, CMD=1, pix_ready_i=1 -> one beat x=5 y=7 r=FF g=80 b=40 at T+3, then STATUS=0x1.
REQ-036 RECT with swap/backpressure: PA(3,2), PB(1,1), pix_ready_i toggling -> beats (1,1),(2,1),(3,1),(1,2),(2,2),(3,2), outputs stable during stalls.
REQ-037 Overflow: pix_ready_i=0, six CMD=2 writes -> engine holds 1, FIFO count=4, STATUS=0x0000_040E; write 0x10 -> STATUS=0x0000_0406.
REQ-038 Clamp: PA(630,0), PB(2000,0), CMD=2 -> 10 beats x=630..639, y=0.
REQ-039 Reset mid-RUN: n_rst low during RECT with FIFO count 2 -> next cycle pix_valid_o=0, STATUS=0x1, no further beats.
